// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch slice.
package if_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN         = 32;

    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One prefetch buffer slot: the fetched word and the byte address it came from.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN-1:0]         instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-side bundle: redirect input, instruction memory port and decode handshake.
interface if_prefetch_if #(
    parameter int unsigned XLEN = if_pkg::XLEN_DEFAULT
) ();
    import if_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    // Prefetcher side.
    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    // Environment side: pipeline control, memory and decode.
    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc
    );

endinterface

// File: rtl/if_fifo.sv
// Synchronous prefetch buffer with push/pop/flush and occupancy count.
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  entry_t                 din_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Next pointer/occupancy; flush empties the buffer and overrides push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads as zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues sequential fetches under credit control,
// tracks the single in-flight read and queues responses for decode.
module if_prefetch
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input logic           clk,
    input logic           reset,
    if_prefetch_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    // Same shape as fetch_entry_t, sized for this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] issue_pc_q, issue_pc_d;
    logic            inflight_q, inflight_d;

    logic [CW-1:0]   count;
    logic [OW-1:0]   occupancy;
    logic            pop;
    logic            issue;
    logic            push;
    entry_t          push_entry;
    entry_t          head;

    // Slots already claimed (buffered + in flight) after this cycle's pop;
    // pop implies count >= 1, so the subtraction cannot underflow.
    assign pop       = bus.out_valid & bus.out_ready;
    assign occupancy = {1'b0, count} + OW'(inflight_q) - OW'(pop);
    assign issue     = ~bus.redirect_valid & (occupancy < OW'(DEPTH));

    // A returning response is dropped when a redirect arrives in the same cycle.
    assign push       = inflight_q & ~bus.redirect_valid;
    assign push_entry = '{pc: issue_pc_q, instr: bus.imem_rdata};

    // Next fetch address, in-flight flag and issuing-PC capture
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            issue_pc_d = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    // Fetch-side state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
        end
    end

    if_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop & ~bus.redirect_valid),
        .flush_i (bus.redirect_valid),
        .din_i   (push_entry),
        .head_o  (head),
        .count_o (count)
    );

    // Request is gated by reset only at the port, so the first fetch is
    // presented as soon as reset releases and taken on the next edge.
    assign bus.imem_req  = issue & reset;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_if_prefetch;
    import if_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] PC0   = 32'h0000_0000;
    localparam logic [31:0] PCW   = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    if_prefetch_if #(.XLEN(XLEN)) bus ();
    if_prefetch_if #(.XLEN(XLEN)) bus2 ();

    if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(PC0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(PCW)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    // Memory contents: word index * 0x11, truncated to 32 bits.
    function automatic logic [31:0] word_val(input logic [31:0] addr);
        return (addr >> 2) * 32'h11;
    endfunction

    // One-cycle read latency memories; garbage when no request was made.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= word_val(bus.imem_addr);
        else              bus.imem_rdata <= $urandom;
        if (bus2.imem_req) bus2.imem_rdata <= word_val(bus2.imem_addr);
        else               bus2.imem_rdata <= $urandom;
    end

    task automatic apply_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.out_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", bus.out_pc); end
        tests++; if (bus.out_instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", bus.out_instr); end
        tests++; if (bus.imem_addr !== PC0) begin fails++; $display("FAIL rst_addr: got %h want %h", bus.imem_addr, PC0); end
        tests++; if (bus2.imem_addr !== PCW) begin fails++; $display("FAIL rst_addr_w: got %h want %h", bus2.imem_addr, PCW); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        apply_reset();
        @(negedge clk); reset = 1'b1; bus.out_ready = 1'b1; #1;
        tests++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL stream_req0: got %b want 1", bus.imem_req); end
        tests++; if (bus.imem_addr !== PC0) begin fails++; $display("FAIL stream_addr0: got %h want %h", bus.imem_addr, PC0); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            if (c < 2) begin
                tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_early c%0d: got %b want 0", c, bus.out_valid); end
            end else begin
                exp_pc = 32'(4 * (c - 2));
                tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid c%0d: got %b want 1", c, bus.out_valid); end
                tests++; if (bus.out_pc !== exp_pc) begin fails++; $display("FAIL stream_pc c%0d: got %h want %h", c, bus.out_pc, exp_pc); end
                tests++; if (bus.out_instr !== 32'(32'h11 * (c - 2))) begin fails++; $display("FAIL stream_instr c%0d: got %h want %h", c, bus.out_instr, 32'(32'h11 * (c - 2))); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        apply_reset();
        @(negedge clk); reset = 1'b1; #1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            if (c >= 2) begin
                exp_pc = PCW + 32'(4 * (c - 2));
                tests++; if (bus2.out_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid c%0d: got %b want 1", c, bus2.out_valid); end
                tests++; if (bus2.out_pc !== exp_pc) begin fails++; $display("FAIL wrap_pc c%0d: got %h want %h", c, bus2.out_pc, exp_pc); end
                tests++; if (bus2.out_instr !== word_val(exp_pc)) begin fails++; $display("FAIL wrap_instr c%0d: got %h want %h", c, bus2.out_instr, word_val(exp_pc)); end
            end
        end
    endtask

    task automatic test_stall();
        int nreq;
        int pops;
        int cyc;
        apply_reset();
        @(negedge clk); reset = 1'b1; bus.out_ready = 1'b0; #1;
        nreq = bus.imem_req ? 1 : 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); #1;
            if (bus.imem_req) nreq++;
            if (c >= 2) begin
                tests++;
                if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h0}) begin
                    fails++; $display("FAIL stall_hold c%0d: got v=%b pc=%h want v=1 pc=0", c, bus.out_valid, bus.out_pc);
                end
            end
        end
        tests++; if (nreq != DEPTH) begin fails++; $display("FAIL stall_nreq: got %0d want %0d", nreq, DEPTH); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL stall_req_off: got %b want 0", bus.imem_req); end
        pops = 0;
        cyc  = 0;
        while (pops < 8 && cyc < 40) begin
            @(negedge clk); bus.out_ready = 1'b1; #1;
            cyc++;
            if (bus.out_valid === 1'b1) begin
                tests++; if (bus.out_pc !== 32'(4 * pops)) begin fails++; $display("FAIL stall_seq %0d: got %h want %h", pops, bus.out_pc, 32'(4 * pops)); end
                tests++; if (bus.out_instr !== 32'(32'h11 * pops)) begin fails++; $display("FAIL stall_instr %0d: got %h want %h", pops, bus.out_instr, 32'(32'h11 * pops)); end
                pops++;
            end
        end
        tests++; if (pops != 8 || cyc != 8) begin fails++; $display("FAIL stall_drain: got %0d pops in %0d cycles want 8 in 8", pops, cyc); end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    task automatic test_redirect();
        apply_reset();
        @(negedge clk); reset = 1'b1; bus.out_ready = 1'b0; #1;
        repeat (3) @(negedge clk);
        // cycle 4: three entries buffered, pc 12 returning, pop offered
        @(negedge clk);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        tests++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h0}) begin fails++; $display("FAIL redir_pre: got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL redir_noreq: got %b want 0", bus.imem_req); end
        step(1'b0, 32'h0);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: got %b want 0", bus.out_valid); end
        tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin fails++; $display("FAIL redir_addr: got req=%b addr=%h want 1/100", bus.imem_req, bus.imem_addr); end
        step(1'b0, 32'h0);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL redir_gap: got %b want 0", bus.out_valid); end
        step(1'b0, 32'h0);
        tests++; if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h100, word_val(32'h100)}) begin fails++; $display("FAIL redir_first: got v=%b pc=%h i=%h want pc=100", bus.out_valid, bus.out_pc, bus.out_instr); end
        step(1'b1, 32'h203);
        step(1'b0, 32'h0);
        tests++; if ({bus.out_valid, bus.imem_addr} !== {1'b0, 32'h200}) begin fails++; $display("FAIL redir_align: got v=%b addr=%h want v=0 addr=200", bus.out_valid, bus.imem_addr); end
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        tests++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h200}) begin fails++; $display("FAIL redir_align_out: got v=%b pc=%h want pc=200", bus.out_valid, bus.out_pc); end
        step(1'b1, 32'h300);
        step(1'b1, 32'h404);
        tests++; if (bus.imem_addr !== 32'h300) begin fails++; $display("FAIL b2b_mid: got %h want 300", bus.imem_addr); end
        step(1'b0, 32'h0);
        tests++; if ({bus.out_valid, bus.imem_addr} !== {1'b0, 32'h404}) begin fails++; $display("FAIL b2b_addr: got v=%b addr=%h want v=0 addr=404", bus.out_valid, bus.imem_addr); end
        step(1'b0, 32'h0);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b want 0", bus.out_valid); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0);
            tests++;
            if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h404 + 32'(4 * k), word_val(32'h404 + 32'(4 * k))}) begin
                fails++; $display("FAIL b2b_out %0d: got v=%b pc=%h i=%h want pc=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, 32'h404 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        @(negedge clk); reset = 1'b1; bus.out_ready = 1'b0; #1;
        repeat (4) @(negedge clk);
        #1;
        tests++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h0}) begin fails++; $display("FAIL mid_pre: got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
        #2; reset = 1'b0; #1;
        tests++; if ({bus.out_valid, bus.imem_req} !== 2'b00) begin fails++; $display("FAIL mid_clear: got v=%b req=%b want 0/0", bus.out_valid, bus.imem_req); end
        tests++; if ({bus.out_pc, bus.out_instr} !== 64'h0) begin fails++; $display("FAIL mid_zero: got pc=%h i=%h want 0/0", bus.out_pc, bus.out_instr); end
        @(negedge clk); reset = 1'b1; bus.out_ready = 1'b1; #1;
        tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, PC0}) begin fails++; $display("FAIL mid_restart: got req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, PC0); end
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, PC0, word_val(PC0)}) begin fails++; $display("FAIL mid_first: got v=%b pc=%h i=%h want pc=%h", bus.out_valid, bus.out_pc, bus.out_instr, PC0); end
    endtask

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } issued_t;

    // Model: every request is a queued transaction that becomes visible two
    // cycles after issue; a redirect discards everything outstanding.
    task automatic test_random();
        issued_t     q[$];
        logic [31:0] mfetch;
        logic        rv, rdy, exp_valid, exp_pop, exp_req;
        logic [31:0] rpc;
        int          nflt;
        apply_reset();
        mfetch = PC0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (c == 0) reset = 1'b1;
            rv  = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = $urandom;
            bus.redirect_valid = rv;
            bus.redirect_pc    = rpc;
            bus.out_ready      = rdy;
            #1;
            exp_valid = 1'b0;
            if (q.size() > 0) exp_valid = (q[0].cyc + 2 <= c);
            exp_pop = exp_valid && rdy;
            nflt    = q.size() - (exp_pop ? 1 : 0);
            exp_req = !rv && (nflt < int'(DEPTH));
            tests++; if (bus.out_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.out_valid, exp_valid); end
            if (exp_valid) begin
                tests++; if (bus.out_pc !== q[0].pc) begin fails++; $display("FAIL rnd_pc c%0d: got %h want %h", c, bus.out_pc, q[0].pc); end
                tests++; if (bus.out_instr !== word_val(q[0].pc)) begin fails++; $display("FAIL rnd_instr c%0d: got %h want %h", c, bus.out_instr, word_val(q[0].pc)); end
            end
            tests++; if (bus.imem_req !== exp_req) begin fails++; $display("FAIL rnd_req c%0d: got %b want %b", c, bus.imem_req, exp_req); end
            tests++; if (bus.imem_addr !== mfetch) begin fails++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.imem_addr, mfetch); end
            if (rv) begin
                q.delete();
                mfetch = rpc & ~32'h3;
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (exp_req) begin
                    q.push_back('{pc: mfetch, cyc: c});
                    mfetch = mfetch + 32'd4;
                end
            end
        end
    endtask

    initial begin
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.out_ready      = 1'b1;
        test_reset();
        test_stream();
        test_wrap();
        test_stall();
        test_redirect();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
